inst_fetch: RTL and testbench
=============================

Name: inst_fetch

Overview:
Instruction fetch unit that produces the 32-bit instruction word consumed by the instruction decoder. It owns the PC, issues single-outstanding word reads to instruction memory over a req/ack handshake, and holds each fetched word with a valid/ready handshake until the core consumes it. On consumption it applies any jump redirect, then fetches the next word. Whenever no valid instruction is held, it drives NOP (32'h00000013) so the decoder's control outputs stay inert.

Parameters:
RESET_PC, 32'h00000000, PC value loaded on reset; must be word-aligned.
NOP_WORD, 32'h00000013, word driven on inst when inst_valid=0 (addi x0,x0,0).

Ports:
clk  in  1  system clock, all state updates on rising edge
nreset  in  1  synchronous, active-low reset
mem_req  out  1  instruction memory read request
mem_addr  out  32  word address of request, always [1:0]=00
mem_ack  in  1  memory returns mem_rdata this cycle
mem_rdata  in  32  fetched instruction word
inst  out  32  instruction to decoder
inst_pc  out  32  address of inst
inst_valid  out  1  inst holds a fetched instruction
inst_ready  in  1  core consumes inst this cycle
jmp_en  in  1  redirect next fetch to jmp_addr (sampled only on consume)
jmp_addr  in  32  redirect target
fetch_fault  out  1  sticky misaligned-target fault

Behaviour:
- Reset (nreset=0 at rising edge): state=RST, pc=RESET_PC, mem_req=0, mem_addr=0, inst=NOP_WORD, inst_pc=0, inst_valid=0, fetch_fault=0. Reset wins over every other input.
- All outputs registered. States: RST, FETCH, HOLD, FAULT.
- RST: mem_req=0. Next edge with nreset=1 -> FETCH with mem_req=1, mem_addr=pc.
- FETCH: mem_req=1, mem_addr=pc, both stable until ack. On mem_ack: inst<=mem_rdata, inst_pc<=pc, inst_valid<=1, mem_req<=0, pc<=pc+4, -> HOLD. Latency: ack at cycle N gives inst_valid=1 at N+1. jmp_en and inst_ready are ignored in FETCH.
- HOLD: inst, inst_pc and inst_valid=1 stay stable until inst_ready=1. On inst_ready:
  - if jmp_en=1 and jmp_addr[1:0]!=00 -> FAULT.
  - else next_pc = jmp_en ? jmp_addr : pc. Set pc<=next_pc, mem_addr<=next_pc, mem_req<=1, inst_valid<=0, inst<=NOP_WORD, -> FETCH.
  - The next request therefore issues on the cycle after consumption. Best-case throughput is one instruction per 2 cycles with zero-wait memory.
- FAULT: fetch_fault=1, mem_req=0, inst_valid=0, inst=NOP_WORD. jmp_en and inst_ready are ignored. Exit only through reset.
- mem_ack is ignored outside FETCH, including a late ack after reset.
- PC arithmetic is 32-bit modulo: pc=32'hFFFFFFFC increments to 32'h00000000 with no fault.
- Reset during FETCH with mem_req high: mem_req=0 from the next edge. An outstanding memory response is discarded.
- Simultaneous mem_ack and reset: reset wins and inst is unchanged from NOP_WORD.
- inst_valid=0 always implies inst=NOP_WORD.

Test Plan:
1. Reset release, RESET_PC=0, 0-wait ack, inst_ready=1 always -> mem_addr sequence 0,4,8. inst=mem_rdata one cycle after each ack. inst_valid pulses every 2nd cycle. inst_pc matches the fetched address.
2. mem_ack delayed 3 cycles, then inst_ready held low 4 cycles after valid -> mem_addr stable for 4 cycles with mem_req high. inst/inst_pc stable for 5 cycles while inst_valid=1. No new request until the cycle after inst_ready.
3. Consume with jmp_en=1, jmp_addr=32'h00000100 -> next mem_addr=0x100. The following fetch uses 0x104. jmp_en asserted during FETCH has no effect.
4. Consume with jmp_en=1, jmp_addr=32'h00000102 -> fetch_fault=1 next cycle, mem_req=0, inst=32'h13. State persists until nreset=0, after which fetch restarts at RESET_PC.
5. pc=32'hFFFFFFFC fetched and consumed without jump -> next mem_addr=0x00000000, fetch_fault stays 0.
6. nreset=0 asserted while mem_req=1, then ack arrives the next cycle -> ack is ignored and inst_valid=0. After reset release, the first mem_addr=RESET_PC.

Source files
------------

// File: rtl/inst_fetch_if.sv
// Fetch-unit bus: instruction-memory req/ack side plus the decoder valid/ready side.
// master = fetch unit, slave = memory/decoder environment.
interface inst_fetch_if;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        inst_valid;
    logic        inst_ready;
    logic        jmp_en;
    logic [31:0] jmp_addr;
    logic        fetch_fault;

    modport master (
        output mem_req, mem_addr, inst, inst_pc, inst_valid, fetch_fault,
        input  mem_ack, mem_rdata, inst_ready, jmp_en, jmp_addr
    );

    modport slave (
        input  mem_req, mem_addr, inst, inst_pc, inst_valid, fetch_fault,
        output mem_ack, mem_rdata, inst_ready, jmp_en, jmp_addr
    );
endinterface

// File: rtl/inst_fetch.sv
// Instruction fetch unit: owns the PC, issues one outstanding word read at a time
// and holds each fetched word for the decoder; all outputs are registered.
module inst_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_WORD = 32'h0000_0013
) (
    input  logic                clk,
    input  logic                nreset,
    inst_fetch_if.master        bus,
    output logic [1:0]          dbg_state
);
    typedef enum logic [1:0] {
        RST   = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2,
        FAULT = 2'd3
    } state_t;

    state_t      state, state_n;
    logic [31:0] pc, pc_n;
    logic [31:0] addr_q, addr_n;
    logic [31:0] inst_q, inst_n;
    logic [31:0] ipc_q, ipc_n;
    logic        req_q, req_n;
    logic        valid_q, valid_n;
    logic        fault_q, fault_n;
    logic [31:0] target;

    always_ff @(posedge clk) begin
        if (!nreset) begin
            state   <= RST;
            pc      <= RESET_PC;
            addr_q  <= 32'h0;
            inst_q  <= NOP_WORD;
            ipc_q   <= 32'h0;
            req_q   <= 1'b0;
            valid_q <= 1'b0;
            fault_q <= 1'b0;
        end else begin
            state   <= state_n;
            pc      <= pc_n;
            addr_q  <= addr_n;
            inst_q  <= inst_n;
            ipc_q   <= ipc_n;
            req_q   <= req_n;
            valid_q <= valid_n;
            fault_q <= fault_n;
        end
    end

    // Handshakes: a memory read is live while mem_req=1 and completes on the cycle
    // mem_ack=1 (mem_addr held until then); a held word transfers on the cycle
    // inst_valid=1 and inst_ready=1, with inst/inst_pc held stable until then.
    always_comb begin
        state_n = state;
        pc_n    = pc;
        addr_n  = addr_q;
        inst_n  = inst_q;
        ipc_n   = ipc_q;
        req_n   = req_q;
        valid_n = valid_q;
        fault_n = fault_q;
        target  = bus.jmp_en ? bus.jmp_addr : pc;
        case (state)
            RST: begin
                state_n = FETCH;
                req_n   = 1'b1;
                addr_n  = pc;
            end
            FETCH: begin
                if (bus.mem_ack) begin
                    state_n = HOLD;
                    inst_n  = bus.mem_rdata;
                    ipc_n   = pc;
                    valid_n = 1'b1;
                    req_n   = 1'b0;
                    pc_n    = pc + 32'd4;
                end
            end
            HOLD: begin
                if (bus.inst_ready) begin
                    valid_n = 1'b0;
                    inst_n  = NOP_WORD;
                    if (bus.jmp_en && (bus.jmp_addr[1:0] != 2'b00)) begin
                        // Misaligned redirect is terminal until reset.
                        state_n = FAULT;
                        fault_n = 1'b1;
                        req_n   = 1'b0;
                    end else begin
                        state_n = FETCH;
                        pc_n    = target;
                        addr_n  = target;
                        req_n   = 1'b1;
                    end
                end
            end
            FAULT: begin
                fault_n = 1'b1;
                req_n   = 1'b0;
                valid_n = 1'b0;
                inst_n  = NOP_WORD;
            end
            default: state_n = RST;
        endcase
    end

    assign bus.mem_req     = req_q;
    assign bus.mem_addr    = addr_q;
    assign bus.inst        = inst_q;
    assign bus.inst_pc     = ipc_q;
    assign bus.inst_valid  = valid_q;
    assign bus.fetch_fault = fault_q;
    assign dbg_state       = state;
endmodule

// File: tb/tb_inst_fetch.sv
// Randomized bench for inst_fetch: a memory/decoder model predicts each request
// address, delivered word and redirect, checked once per cycle on the falling edge.
module tb_inst_fetch;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] NOP      = 32'h0000_0013;

    logic       clk = 1'b0;
    logic       nreset;
    logic [1:0] dbg_state;

    inst_fetch_if bus();

    inst_fetch #(.RESET_PC(RESET_PC), .NOP_WORD(NOP)) dut (
        .clk       (clk),
        .nreset    (nreset),
        .bus       (bus.master),
        .dbg_state (dbg_state)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // model of the environment's view of the fetch unit
    logic [31:0] cur_addr;
    logic        outstanding, holding, faulted, pending_release;
    logic        wrap_seen;
    int          lat, rwait;
    int          lat_min, lat_max, rdy_min, rdy_max, jmp_pct;
    logic        force_jmp;
    logic [31:0] force_tgt;

    function automatic logic [31:0] word_at(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'hC0DE_0001;
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic start_fetch(input logic [31:0] a);
        cur_addr    = a;
        outstanding = 1'b1;
        lat         = $urandom_range(lat_max, lat_min);
    endtask

    task automatic noise_jump();
        bus.jmp_en   = 1'($urandom_range(0, 1));
        bus.jmp_addr = $urandom;
    endtask

    // One cycle: check outputs produced by the edge just passed, then drive inputs.
    task automatic step();
        @(negedge clk);
        if (!nreset) begin
            outstanding     = 1'b0;
            holding         = 1'b0;
            faulted         = 1'b0;
            pending_release = 1'b1;
            check_eq("rst_req",   32'(bus.mem_req), 32'd0);
            check_eq("rst_addr",  bus.mem_addr, 32'h0);
            check_eq("rst_inst",  bus.inst, NOP);
            check_eq("rst_ipc",   bus.inst_pc, 32'h0);
            check_eq("rst_valid", 32'(bus.inst_valid), 32'd0);
        end else if (pending_release) begin
            pending_release = 1'b0;
            check_eq("first_req",  32'(bus.mem_req), 32'd1);
            check_eq("first_addr", bus.mem_addr, RESET_PC);
            check_eq("first_valid", 32'(bus.inst_valid), 32'd0);
            start_fetch(RESET_PC);
        end else if (faulted) begin
            check_eq("flt_req",   32'(bus.mem_req), 32'd0);
            check_eq("flt_valid", 32'(bus.inst_valid), 32'd0);
            check_eq("flt_inst",  bus.inst, NOP);
        end else if (outstanding && bus.mem_ack) begin
            outstanding = 1'b0;
            holding     = 1'b1;
            rwait       = $urandom_range(rdy_max, rdy_min);
            check_eq("ack_valid", 32'(bus.inst_valid), 32'd1);
            check_eq("ack_inst",  bus.inst, word_at(cur_addr));
            check_eq("ack_ipc",   bus.inst_pc, cur_addr);
            check_eq("ack_req",   32'(bus.mem_req), 32'd0);
        end else if (outstanding) begin
            check_eq("wait_req",   32'(bus.mem_req), 32'd1);
            check_eq("wait_addr",  bus.mem_addr, cur_addr);
            check_eq("wait_valid", 32'(bus.inst_valid), 32'd0);
            check_eq("wait_inst",  bus.inst, NOP);
        end else if (holding && bus.inst_ready) begin
            holding = 1'b0;
            check_eq("cons_valid", 32'(bus.inst_valid), 32'd0);
            check_eq("cons_inst",  bus.inst, NOP);
            if (bus.jmp_en && bus.jmp_addr[1:0] != 2'b00) begin
                faulted = 1'b1;
                check_eq("cons_fault_req", 32'(bus.mem_req), 32'd0);
            end else begin
                if (!bus.jmp_en && cur_addr == 32'hFFFF_FFFC) wrap_seen = 1'b1;
                start_fetch(bus.jmp_en ? bus.jmp_addr : cur_addr + 32'd4);
                check_eq("cons_req",  32'(bus.mem_req), 32'd1);
                check_eq("cons_addr", bus.mem_addr, cur_addr);
            end
        end else if (holding) begin
            check_eq("hold_valid", 32'(bus.inst_valid), 32'd1);
            check_eq("hold_inst",  bus.inst, word_at(cur_addr));
            check_eq("hold_ipc",   bus.inst_pc, cur_addr);
            check_eq("hold_req",   32'(bus.mem_req), 32'd0);
        end
        check_eq("fault", 32'(bus.fetch_fault), 32'(faulted));

        if (outstanding) begin
            if (lat == 0) begin
                bus.mem_ack   = 1'b1;
                bus.mem_rdata = word_at(cur_addr);
            end else begin
                bus.mem_ack   = 1'b0;
                bus.mem_rdata = $urandom;
                lat--;
            end
        end else begin
            bus.mem_ack   = ($urandom_range(0, 3) == 0);
            bus.mem_rdata = $urandom;
        end

        if (holding && rwait == 0) begin
            bus.inst_ready = 1'b1;
            if (force_jmp) begin
                bus.jmp_en   = 1'b1;
                bus.jmp_addr = force_tgt;
                force_jmp    = 1'b0;
            end else if ($urandom_range(0, 99) < jmp_pct) begin
                bus.jmp_en   = 1'b1;
                bus.jmp_addr = 32'($urandom_range(0, 1023)) << 2;
            end else begin
                bus.jmp_en   = 1'b0;
                bus.jmp_addr = $urandom;
            end
        end else begin
            if (holding) begin
                bus.inst_ready = 1'b0;
                rwait--;
            end else begin
                bus.inst_ready = 1'($urandom_range(0, 1));
            end
            noise_jump();
        end
    endtask

    task automatic set_knobs(input int lmin, input int lmax, input int rmin, input int rmax, input int jp);
        lat_min = lmin;
        lat_max = lmax;
        rdy_min = rmin;
        rdy_max = rmax;
        jmp_pct = jp;
    endtask

    task automatic do_reset();
        nreset = 1'b0;
        step();
        step();
        nreset = 1'b1;
    endtask

    initial begin
        nreset        = 1'b0;
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = 32'h0;
        bus.inst_ready = 1'b0;
        bus.jmp_en    = 1'b0;
        bus.jmp_addr  = 32'h0;
        outstanding = 1'b0; holding = 1'b0; faulted = 1'b0; pending_release = 1'b0;
        wrap_seen = 1'b0; force_jmp = 1'b0; force_tgt = 32'h0;
        cur_addr = 32'h0; lat = 0; rwait = 0;
        set_knobs(0, 0, 0, 0, 0);

        // zero-wait memory, always-ready decoder: sequential 0,4,8,...
        step();
        step();
        nreset = 1'b1;
        repeat (14) step();

        // slow memory (3 cycles) and slow decoder (4 cycles)
        set_knobs(3, 3, 4, 4, 0);
        repeat (30) step();

        // random mix with aligned redirects and ignored jmp/ack noise
        set_knobs(0, 3, 0, 3, 25);
        repeat (300) step();

        // redirect to 0x100, then sequential to 0x104
        set_knobs(0, 2, 0, 2, 0);
        force_jmp = 1'b1;
        force_tgt = 32'h0000_0100;
        repeat (30) step();

        // redirect to the top word; the following fetch wraps to 0
        force_jmp = 1'b1;
        force_tgt = 32'hFFFF_FFFC;
        repeat (30) step();
        check_eq("wrap_seen", 32'(wrap_seen), 32'd1);

        // misaligned redirect: sticky fault until reset
        force_jmp = 1'b1;
        force_tgt = 32'h0000_0102;
        repeat (30) step();
        check_eq("fault_sticky", 32'(bus.fetch_fault), 32'd1);
        do_reset();
        repeat (20) step();

        // reset while a request is outstanding, with acks during reset
        set_knobs(5, 5, 0, 1, 0);
        for (int i = 0; i < 40 && !(outstanding && lat > 1); i++) step();
        check_eq("req_before_rst", 32'(bus.mem_req), 32'd1);
        nreset        = 1'b0;
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = $urandom;
        step();
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = $urandom;
        step();
        nreset = 1'b1;
        repeat (10) step();

        set_knobs(0, 3, 0, 3, 20);
        repeat (200) step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
